// File: rtl/vga_seg_renderer.sv
// ---------------------------------------------------------------------------
// vga_seg_renderer
//
// Seven-segment clock renderer for the 640x480 VGA path. It turns the VGA
// horizontal/vertical counters into a single pixel drive enable for
// NUM_DIGITS digits. The digits are grouped in pairs, with a two-dot colon
// between each pair. Digit patterns are captured into shadow registers on
// frame_start, so a time update never tears mid-frame. The pixel path has a
// fixed latency of two clocks.
//
// Optional feature macro: COLON_BLINK_EN
//   defined   : a frame counter toggles colon_phase every BLINK_FRAMES frames,
//               and colons are drawn only while colon_phase = 1.
//   undefined : colon_phase is tied to 1 and colons are always drawn.
//
// Ports
//   clk           in   pixel clock
//   rst           in   synchronous, active-high reset
//   horiz_cnt     in   [9:0] VGA horizontal counter
//   vert_cnt      in   [9:0] VGA vertical counter
//   frame_start   in   one-cycle pulse per frame, loads the shadow digits
//   digits        in   [7*NUM_DIGITS-1:0] digit k at [7k+6:7k], bit0=a..bit6=g,
//                      active-low (0 = segment lit)
//   display_en    in   0 forces the pixel dark
//   drive_enable  out  pixel lit, registered (two clocks after the pixel)
//   colon_phase   out  current colon visibility
// ---------------------------------------------------------------------------
module vga_seg_renderer #(
  parameter int NUM_DIGITS   = 6,
  parameter int H_BIAS       = 144,
  parameter int H_ORIGIN     = 50,
  parameter int V_ORIGIN     = 150,
  parameter int SEG_W        = 65,
  parameter int SEG_T        = 15,
  parameter int VSEG_H       = 70,
  parameter int VSEG_T       = 10,
  parameter int GAP          = 20,
  parameter int COLON_W      = 14,
  parameter int COLON_H      = 17,
  parameter int COLON_V0     = 200,
  parameter int COLON_GAP    = 60,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [9:0]              horiz_cnt,
  input  logic [9:0]              vert_cnt,
  input  logic                    frame_start,
  input  logic [7*NUM_DIGITS-1:0] digits,
  input  logic                    display_en,
  output logic                    drive_enable,
  output logic                    colon_phase
);

  // -------------------------------------------------------------------------
  // Elaboration-time geometry
  // -------------------------------------------------------------------------
  localparam int NUM_COLONS = NUM_DIGITS / 2 - 1;
  // Keeps the colon vectors at least one bit wide for a two-digit build.
  localparam int COLON_REGS = (NUM_COLONS > 0) ? NUM_COLONS : 1;

  localparam int H0 = H_BIAS + H_ORIGIN;
  localparam int Y1 = V_ORIGIN + SEG_T;
  localparam int Y2 = Y1 + VSEG_H;
  localparam int Y3 = Y2 + SEG_T;
  localparam int Y4 = Y3 + VSEG_H;

  localparam int COLON_UP_TOP = COLON_V0;
  localparam int COLON_UP_BOT = COLON_V0 + COLON_H;
  localparam int COLON_LO_TOP = COLON_UP_BOT + COLON_GAP;
  localparam int COLON_LO_BOT = COLON_LO_TOP + COLON_H;

  if ((NUM_DIGITS < 2) || (NUM_DIGITS > 8) || ((NUM_DIGITS % 2) != 0) ||
      (BLINK_FRAMES < 1)) begin : gBadParams
    $error("vga_seg_renderer: NUM_DIGITS must be even in 2..8 and BLINK_FRAMES >= 1");
  end

  // Inclusive, unsigned 10-bit range test against constant bounds.
  function automatic logic inRange(input logic [9:0] x, input int lo, input int hi);
    return (x >= 10'(lo)) && (x <= 10'(hi));
  endfunction

  // -------------------------------------------------------------------------
  // Row bands, shared by every digit / colon
  // -------------------------------------------------------------------------
  logic rowA, rowBF, rowG, rowCE, rowD;
  logic rowColonUp, rowColonLo;

  assign rowA       = inRange(vert_cnt, V_ORIGIN, Y1);
  assign rowBF      = inRange(vert_cnt, Y1, Y2);
  assign rowG       = inRange(vert_cnt, Y2, Y3);
  assign rowCE      = inRange(vert_cnt, Y3, Y4);
  assign rowD       = inRange(vert_cnt, Y4, Y4 + SEG_T);
  assign rowColonUp = inRange(vert_cnt, COLON_UP_TOP, COLON_UP_BOT);
  assign rowColonLo = inRange(vert_cnt, COLON_LO_TOP, COLON_LO_BOT);

  // -------------------------------------------------------------------------
  // Per-segment region hits (bit order matches the digits bus: a..g)
  // -------------------------------------------------------------------------
  logic [7*NUM_DIGITS-1:0] segHitComb;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : gDigit
    localparam int L = H0 + k * (SEG_W + GAP) + (k / 2) * (COLON_W + GAP);

    logic colFull;
    logic colLeft;
    logic colRight;

    assign colFull  = inRange(horiz_cnt, L, L + SEG_W);
    assign colLeft  = inRange(horiz_cnt, L, L + VSEG_T);
    assign colRight = inRange(horiz_cnt, L + SEG_W - VSEG_T, L + SEG_W);

    assign segHitComb[7*k + 0] = colFull  & rowA;   // a
    assign segHitComb[7*k + 1] = colRight & rowBF;  // b
    assign segHitComb[7*k + 2] = colRight & rowCE;  // c
    assign segHitComb[7*k + 3] = colFull  & rowD;   // d
    assign segHitComb[7*k + 4] = colLeft  & rowCE;  // e
    assign segHitComb[7*k + 5] = colLeft  & rowBF;  // f
    assign segHitComb[7*k + 6] = colFull  & rowG;   // g
  end

  // -------------------------------------------------------------------------
  // Per-colon region hits (both dots of a colon fold into one flag)
  // -------------------------------------------------------------------------
  logic [COLON_REGS-1:0] colonHitComb;

  for (genvar j = 0; j < COLON_REGS; j++) begin : gColon
    if (j < NUM_COLONS) begin : gLive
      localparam int CL = H0 + (2 * j + 2) * (SEG_W + GAP);
      logic colColon;
      assign colColon        = inRange(horiz_cnt, CL, CL + COLON_W);
      assign colonHitComb[j] = colColon & (rowColonUp | rowColonLo);
    end else begin : gNone
      assign colonHitComb[j] = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 1: register region hits and display enable
  // -------------------------------------------------------------------------
  logic [7*NUM_DIGITS-1:0] segHitQ;
  logic [COLON_REGS-1:0]   colonHitQ;
  logic                    displayEnQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      segHitQ    <= '0;
      colonHitQ  <= '0;
      displayEnQ <= 1'b0;
    end else begin
      segHitQ    <= segHitComb;
      colonHitQ  <= colonHitComb;
      displayEnQ <= display_en;
    end
  end

  // -------------------------------------------------------------------------
  // Shadow digit patterns. Loaded on the same edge as stage 1, so the pixel
  // presented alongside frame_start is rendered with the new pattern.
  // -------------------------------------------------------------------------
  logic [7*NUM_DIGITS-1:0] shadowDigits;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadowDigits <= '1;
    end else if (frame_start) begin
      shadowDigits <= digits;
    end
  end

  // -------------------------------------------------------------------------
  // Colon phase
  // -------------------------------------------------------------------------
`ifdef COLON_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

  logic [FC_W-1:0] frameCnt;

  // The wrap and the phase toggle share one edge, so each phase lasts
  // exactly BLINK_FRAMES frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      frameCnt    <= '0;
      colon_phase <= 1'b1;
    end else if (frame_start) begin
      if (frameCnt == FC_LAST) begin
        frameCnt    <= '0;
        colon_phase <= ~colon_phase;
      end else begin
        frameCnt <= frameCnt + 1'b1;
      end
    end
  end
`else
  assign colon_phase = 1'b1;
`endif

  // -------------------------------------------------------------------------
  // Stage 2: combine hits with the lit pattern and register the pixel
  // -------------------------------------------------------------------------
  logic segLit;
  logic colonLit;
  logic pixelLit;

  // Overlapping edges light when any covering segment is lit.
  assign segLit   = |(segHitQ & ~shadowDigits);
  assign colonLit = (|colonHitQ) & colon_phase;
  assign pixelLit = displayEnQ & (segLit | colonLit);

  always_ff @(posedge clk) begin
    if (rst) begin
      drive_enable <= 1'b0;
    end else begin
      drive_enable <= pixelLit;
    end
  end

endmodule

// File: tb/tb_vga_seg_renderer.sv
// Testbench for vga_seg_renderer (default parameters, NUM_DIGITS = 6).
// Build with +define+COLON_BLINK_EN to add the blink sequence.
module tb_vga_seg_renderer;

  localparam int TB_BLINK = 2;

  localparam logic [6:0] DARK  = 7'h7F;
  localparam logic [6:0] P8    = 7'b0000000;
  localparam logic [6:0] P1    = 7'b1111001;
  localparam logic [6:0] P0    = 7'b1000000;
  localparam logic [6:0] PA    = 7'b1111110;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  horiz_cnt = '0;
  logic [9:0]  vert_cnt = '0;
  logic        frame_start = 1'b0;
  logic [41:0] digits = '1;
  logic        display_en = 1'b1;
  logic        drive_enable;
  logic        colon_phase;

  vga_seg_renderer #(.BLINK_FRAMES(TB_BLINK)) dut (
    .clk          (clk),
    .rst          (rst),
    .horiz_cnt    (horiz_cnt),
    .vert_cnt     (vert_cnt),
    .frame_start  (frame_start),
    .digits       (digits),
    .display_en   (display_en),
    .drive_enable (drive_enable),
    .colon_phase  (colon_phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [41:0] digs;
    logic [9:0]  h;
    logic [9:0]  v;
    logic        de;
    logic        exp;
    bit          isColon;
    string       nm;
  } vec_t;

  typedef struct {
    logic  exp;
    string nm;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   checks = 0;
  int   passes = 0;

  // Reference colon phase model
  logic phaseM = 1'b1;
  int   cntM = 0;

  function automatic logic [41:0] d0(input logic [6:0] p);
    return {DARK, DARK, DARK, DARK, DARK, p};
  endfunction

  function automatic logic [41:0] d1(input logic [6:0] p);
    return {DARK, DARK, DARK, DARK, p, DARK};
  endfunction

  function automatic logic [41:0] d3(input logic [6:0] p);
    return {DARK, DARK, p, DARK, DARK, DARK};
  endfunction

  task automatic chk(input string nm, input logic got, input logic exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0b expected %0b", nm, got, exp);
  endtask

  task automatic frameModel();
`ifdef COLON_BLINK_EN
    if (cntM == TB_BLINK - 1) begin
      cntM   = 0;
      phaseM = ~phaseM;
    end else begin
      cntM++;
    end
`endif
  endtask

  // One pixel per clock; its expectation is scored two edges later.
  task automatic step(input logic [9:0] h, input logic [9:0] v, input logic de,
                      input logic fs, input logic [41:0] d, input logic exp,
                      input bit isColon, input string nm);
    sb_t item;
    sb_t old;
    @(negedge clk);
    horiz_cnt   = h;
    vert_cnt    = v;
    display_en  = de;
    frame_start = fs;
    digits      = d;
    if (fs) frameModel();
    item.exp = isColon ? (exp & phaseM) : exp;
    item.nm  = nm;
    sb.push_back(item);
    @(posedge clk);
    #1;
    if (sb.size() == 2) begin
      old = sb.pop_front();
      chk(old.nm, drive_enable, old.exp);
    end
    chk("colon_phase", colon_phase, phaseM);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(10'd0, 10'd0, 1'b1, 1'b0, digits, 1'b0, 1'b0, "idle");
  endtask

  task automatic doReset();
    @(negedge clk);
    rst         = 1'b1;
    frame_start = 1'b0;
    sb.delete();
    phaseM = 1'b1;
    cntM   = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_drive_enable", drive_enable, 1'b0);
      chk("rst_colon_phase", colon_phase, 1'b1);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // {digits, h, v, display_en, expected, colon pixel, name}
    vecs.push_back('{d0(P8), 10'd200, 10'd155, 1'b1, 1'b1, 1'b0, "d0_8_seg_a"});
    vecs.push_back('{d0(P8), 10'd150, 10'd155, 1'b1, 1'b0, 1'b0, "left_of_d0"});
    vecs.push_back('{d0(P1), 10'd200, 10'd155, 1'b1, 1'b0, 1'b0, "d0_1_seg_a"});
    vecs.push_back('{d0(P1), 10'd256, 10'd200, 1'b1, 1'b1, 1'b0, "d0_1_seg_b"});
    vecs.push_back('{d0(P1), 10'd256, 10'd300, 1'b1, 1'b1, 1'b0, "d0_1_seg_c"});
    vecs.push_back('{d0(P8), 10'd194, 10'd150, 1'b1, 1'b1, 1'b0, "a_top_left"});
    vecs.push_back('{d0(P8), 10'd259, 10'd150, 1'b1, 1'b1, 1'b0, "a_top_right"});
    vecs.push_back('{d0(P8), 10'd260, 10'd150, 1'b1, 1'b0, 1'b0, "a_right_out"});
    vecs.push_back('{d0(P8), 10'd200, 10'd149, 1'b1, 1'b0, 1'b0, "a_above"});
    vecs.push_back('{d0(P1), 10'd255, 10'd165, 1'b1, 1'b1, 1'b0, "ab_edge_b"});
    vecs.push_back('{d0(PA), 10'd255, 10'd165, 1'b1, 1'b1, 1'b0, "ab_edge_a"});
    vecs.push_back('{d0(P1), 10'd230, 10'd165, 1'b1, 1'b0, 1'b0, "a_dark_y1"});
    vecs.push_back('{d0(P8), 10'd220, 10'd240, 1'b1, 1'b1, 1'b0, "g_lit"});
    vecs.push_back('{d0(P0), 10'd220, 10'd240, 1'b1, 1'b0, 1'b0, "g_dark"});
    vecs.push_back('{d0(P8), 10'd197, 10'd280, 1'b1, 1'b1, 1'b0, "e_lit"});
    vecs.push_back('{d0(P8), 10'd220, 10'd335, 1'b1, 1'b1, 1'b0, "d_bottom"});
    vecs.push_back('{d0(P8), 10'd220, 10'd336, 1'b1, 1'b0, 1'b0, "below_d"});
    vecs.push_back('{d0(P8), 10'd200, 10'd155, 1'b0, 1'b0, 1'b0, "display_off"});
    vecs.push_back('{d1(P1), 10'd340, 10'd200, 1'b1, 1'b1, 1'b0, "d1_1_seg_b"});
    vecs.push_back('{d3(P8), 10'd490, 10'd155, 1'b1, 1'b1, 1'b0, "d3_8_seg_a"});
    vecs.push_back('{d0(P8), 10'd700, 10'd155, 1'b1, 1'b0, 1'b0, "h_blank"});
    vecs.push_back('{d0(P8), 10'd200, 10'd500, 1'b1, 1'b0, 1'b0, "v_blank"});
    vecs.push_back('{d0(P8), 10'd1000, 10'd1000, 1'b1, 1'b0, 1'b0, "far_out"});
    vecs.push_back('{'1, 10'd369, 10'd205, 1'b1, 1'b1, 1'b1, "colon_up"});
    vecs.push_back('{'1, 10'd369, 10'd285, 1'b1, 1'b1, 1'b1, "colon_lo"});
    vecs.push_back('{'1, 10'd378, 10'd217, 1'b1, 1'b1, 1'b1, "colon_corner"});
    vecs.push_back('{'1, 10'd369, 10'd218, 1'b1, 1'b0, 1'b1, "colon_between"});
    vecs.push_back('{'1, 10'd369, 10'd300, 1'b1, 1'b0, 1'b1, "colon_below"});
    vecs.push_back('{'1, 10'd363, 10'd205, 1'b1, 1'b0, 1'b1, "colon_left"});
    vecs.push_back('{'1, 10'd369, 10'd205, 1'b0, 1'b0, 1'b1, "colon_disp_off"});

    // Reset with counters sitting on segment a of digit 0
    horiz_cnt = 10'd200;
    vert_cnt  = 10'd155;
    digits    = '0;
    doReset();

    // Table: every vector loads its own pattern with frame_start
    foreach (vecs[i])
      step(vecs[i].h, vecs[i].v, vecs[i].de, 1'b1, vecs[i].digs, vecs[i].exp,
           vecs[i].isColon, vecs[i].nm);
    idle(2);

    // Exact two-cycle latency: alternating lit/dark pixels
    step(10'd200, 10'd155, 1'b1, 1'b1, d0(P8), 1'b1, 1'b0, "lat_on0");
    step(10'd150, 10'd155, 1'b1, 1'b0, d0(P8), 1'b0, 1'b0, "lat_off0");
    step(10'd200, 10'd155, 1'b1, 1'b0, d0(P8), 1'b1, 1'b0, "lat_on1");
    step(10'd150, 10'd155, 1'b1, 1'b0, d0(P8), 1'b0, 1'b0, "lat_off1");

    // Shadow tearing: new digits without frame_start are ignored
    for (int i = 0; i < 3; i++)
      step(10'd200, 10'd155, 1'b1, 1'b0, '1, 1'b1, 1'b0, "tear_hold");
    step(10'd200, 10'd155, 1'b1, 1'b1, '1, 1'b0, 1'b0, "tear_load");
    step(10'd200, 10'd155, 1'b1, 1'b0, d0(P8), 1'b0, 1'b0, "tear_after");
    idle(2);

    // Reset mid-frame: digits stay dark until the next frame_start
    step(10'd200, 10'd155, 1'b1, 1'b1, d0(P8), 1'b1, 1'b0, "pre_rst_load");
    step(10'd200, 10'd155, 1'b1, 1'b0, d0(P8), 1'b1, 1'b0, "pre_rst_on");
    doReset();
    for (int i = 0; i < 3; i++)
      step(10'd200, 10'd155, 1'b1, 1'b0, d0(P8), 1'b0, 1'b0, "post_rst_dark");
    step(10'd200, 10'd155, 1'b1, 1'b1, d0(P8), 1'b1, 1'b0, "post_rst_load");
    idle(2);

`ifdef COLON_BLINK_EN
    doReset();
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 3; i++)
        step(10'd369, 10'd205, 1'b1, 1'b0, '1, 1'b1, 1'b1, "blink_colon");
      step(10'd0, 10'd0, 1'b1, 1'b1, '1, 1'b0, 1'b0, "blink_fs");
    end
    idle(2);
    step(10'd0, 10'd0, 1'b1, 1'b1, '1, 1'b0, 1'b0, "blink_fs_pre_rst");
    doReset();
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 3; i++)
        step(10'd369, 10'd205, 1'b1, 1'b0, '1, 1'b1, 1'b1, "blink_after_rst");
      step(10'd0, 10'd0, 1'b1, 1'b1, '1, 1'b0, 1'b0, "blink_fs2");
    end
    idle(2);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
